// File: rtl/sap_pkg.sv
// Shared encodings for the SAP microsequencer: opcodes, T-state numbers and the
// control-word layout carried between the microcode ROM and the top.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam int CW_W = 15;

    typedef struct packed {
        logic out_load;
        logic flags_load;
        logic alu_sub;
        logic alu_enable;
        logic b_load;
        logic a_enable;
        logic a_load;
        logic ir_enable;
        logic ir_load;
        logic ram_load;
        logic ram_enable;
        logic mar_load;
        logic pc_enable;
        logic pc_load;
        logic pc_inc;
    } ctrl_word_t;

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (step, opcode, flags) -> control word plus a flag
// marking the final step of the instruction. Unused opcodes and HLT decode as NOP.
module sap_microcode_rom
    import sap_pkg::*;
(
    input  logic [2:0]  step,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output ctrl_word_t  cw,
    output logic        last_step
);

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        case (step)
            T0: begin
                cw.pc_enable = 1'b1;
                cw.mar_load  = 1'b1;
            end
            T1: begin
                cw.ram_enable = 1'b1;
                cw.ir_load    = 1'b1;
                cw.pc_inc     = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw.ir_enable = 1'b1;
                        cw.mar_load  = 1'b1;
                    end
                    OP_LDI: begin
                        cw.ir_enable = 1'b1;
                        cw.a_load    = 1'b1;
                        last_step    = 1'b1;
                    end
                    OP_JMP: begin
                        cw.ir_enable = 1'b1;
                        cw.pc_load   = 1'b1;
                        last_step    = 1'b1;
                    end
                    OP_JC: begin
                        cw.ir_enable = flag_c;
                        cw.pc_load   = flag_c;
                        last_step    = 1'b1;
                    end
                    OP_JZ: begin
                        cw.ir_enable = flag_z;
                        cw.pc_load   = flag_z;
                        last_step    = 1'b1;
                    end
                    OP_OUT: begin
                        cw.a_enable = 1'b1;
                        cw.out_load = 1'b1;
                        last_step   = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw.ram_enable = 1'b1;
                        cw.a_load     = 1'b1;
                        last_step     = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.ram_enable = 1'b1;
                        cw.b_load     = 1'b1;
                    end
                    OP_STA: begin
                        cw.a_enable = 1'b1;
                        cw.ram_load = 1'b1;
                        last_step   = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.alu_enable = 1'b1;
                    cw.a_load     = 1'b1;
                    cw.flags_load = 1'b1;
                    cw.alu_sub    = (opcode == OP_SUB);
                end
            end
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/sap_control_unit.sv
// SAP CPU microsequencer: step counter and halt latch around the microcode ROM.
// Strobes are combinational and forced low during reset and while halted.
module sap_control_unit
    import sap_pkg::*;
#(
    parameter int         T_LAST     = 4,
    parameter logic [3:0] HLT_OPCODE = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       pc_enable,
    output logic       mar_load,
    output logic       ram_enable,
    output logic       ram_load,
    output logic       ir_load,
    output logic       ir_enable,
    output logic       a_load,
    output logic       a_enable,
    output logic       b_load,
    output logic       alu_enable,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] t_state
);

    localparam logic [2:0] T_LAST_STEP = 3'(T_LAST);

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;
    ctrl_word_t rom_cw, cw;
    logic       last_step;

    sap_microcode_rom u_rom (
        .step      (step_q),
        .opcode    (opcode),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .cw        (rom_cw),
        .last_step (last_step)
    );

    // HLT leaves the counter parked on T2 so t_state reads 2 while halted.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (step_q == T2 && opcode == HLT_OPCODE) begin
                halted_d = 1'b1;
            end else if (last_step || step_q >= T_LAST_STEP) begin
                step_d = T0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        cw = rom_cw;
        if (rst || halted_q) begin
            cw = '0;
        end
    end

    assign pc_inc     = cw.pc_inc;
    assign pc_load    = cw.pc_load;
    assign pc_enable  = cw.pc_enable;
    assign mar_load   = cw.mar_load;
    assign ram_enable = cw.ram_enable;
    assign ram_load   = cw.ram_load;
    assign ir_load    = cw.ir_load;
    assign ir_enable  = cw.ir_enable;
    assign a_load     = cw.a_load;
    assign a_enable   = cw.a_enable;
    assign b_load     = cw.b_load;
    assign alu_enable = cw.alu_enable;
    assign alu_sub    = cw.alu_sub;
    assign flags_load = cw.flags_load;
    assign out_load   = cw.out_load;
    assign halted     = halted_q;
    assign t_state    = step_q;

endmodule

// File: tb/tb_sap_control_unit.sv
// Scoreboard bench: an instruction-level model pushes the expected per-cycle
// strobes; a negedge monitor pops and compares every cycle.
module tb_sap_control_unit;

    localparam logic [14:0] S_PC_INC   = 15'h0001;
    localparam logic [14:0] S_PC_LOAD  = 15'h0002;
    localparam logic [14:0] S_PC_EN    = 15'h0004;
    localparam logic [14:0] S_MAR_LD   = 15'h0008;
    localparam logic [14:0] S_RAM_EN   = 15'h0010;
    localparam logic [14:0] S_RAM_LD   = 15'h0020;
    localparam logic [14:0] S_IR_LD    = 15'h0040;
    localparam logic [14:0] S_IR_EN    = 15'h0080;
    localparam logic [14:0] S_A_LD     = 15'h0100;
    localparam logic [14:0] S_A_EN     = 15'h0200;
    localparam logic [14:0] S_B_LD     = 15'h0400;
    localparam logic [14:0] S_ALU_EN   = 15'h0800;
    localparam logic [14:0] S_ALU_SUB  = 15'h1000;
    localparam logic [14:0] S_FLAGS_LD = 15'h2000;
    localparam logic [14:0] S_OUT_LD   = 15'h4000;

    typedef struct {
        logic [14:0] cw;
        logic        hlt;
        logic [2:0]  t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       flag_c, flag_z;
    logic pc_inc, pc_load, pc_enable, mar_load, ram_enable, ram_load, ir_load;
    logic ir_enable, a_load, a_enable, b_load, alu_enable, alu_sub, flags_load;
    logic out_load, halted;
    logic [2:0] t_state;

    exp_t sb_q[$];
    bit   mon_en = 1'b0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    sap_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_enable(pc_enable),
        .mar_load(mar_load), .ram_enable(ram_enable), .ram_load(ram_load),
        .ir_load(ir_load), .ir_enable(ir_enable), .a_load(a_load),
        .a_enable(a_enable), .b_load(b_load), .alu_enable(alu_enable),
        .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
        .halted(halted), .t_state(t_state)
    );

    wire [14:0] act_cw = {out_load, flags_load, alu_sub, alu_enable, b_load,
                          a_enable, a_load, ir_enable, ir_load, ram_load,
                          ram_enable, mar_load, pc_enable, pc_load, pc_inc};

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            cmp_cnt++;
            if ($countones({pc_enable, ram_enable, ir_enable, a_enable, alu_enable}) > 1
                || (pc_load && pc_inc)) begin
                err_cnt++;
                $display("FAIL bus_invariant t=%0t cw=%h", $time, act_cw);
            end
            cmp_cnt++;
            if (sb_q.size() == 0) begin
                err_cnt++;
                $display("FAIL sb_underflow t=%0t actual cw=%h required an expected entry", $time, act_cw);
            end else begin
                e = sb_q.pop_front();
                if (act_cw !== e.cw || halted !== e.hlt || t_state !== e.t) begin
                    err_cnt++;
                    $display("FAIL cycle t=%0t actual cw=%h halted=%b t_state=%0d required cw=%h halted=%b t_state=%0d",
                             $time, act_cw, halted, t_state, e.cw, e.hlt, e.t);
                end
            end
        end
    end

    task automatic push_rec(input logic [14:0] cw, input logic h, input logic [2:0] t);
        exp_t r;
        r.cw = cw; r.hlt = h; r.t = t;
        sb_q.push_back(r);
    endtask

    // Reference: list of microsteps per instruction, index = T-state.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
        logic [14:0] ex[$];
        ex.push_back(S_PC_EN | S_MAR_LD);
        ex.push_back(S_RAM_EN | S_IR_LD | S_PC_INC);
        case (op)
            4'h1: begin ex.push_back(S_IR_EN | S_MAR_LD); ex.push_back(S_RAM_EN | S_A_LD); end
            4'h2, 4'h3: begin
                ex.push_back(S_IR_EN | S_MAR_LD);
                ex.push_back(S_RAM_EN | S_B_LD);
                ex.push_back(S_ALU_EN | S_A_LD | S_FLAGS_LD | ((op == 4'h3) ? S_ALU_SUB : 15'h0));
            end
            4'h4: begin ex.push_back(S_IR_EN | S_MAR_LD); ex.push_back(S_A_EN | S_RAM_LD); end
            4'h5: ex.push_back(S_IR_EN | S_A_LD);
            4'h6: ex.push_back(S_IR_EN | S_PC_LOAD);
            4'h7: ex.push_back(c ? (S_IR_EN | S_PC_LOAD) : 15'h0);
            4'h8: ex.push_back(z ? (S_IR_EN | S_PC_LOAD) : 15'h0);
            4'hE: ex.push_back(S_A_EN | S_OUT_LD);
            default: ex.push_back(15'h0);
        endcase
        foreach (ex[i]) push_rec(ex[i], 1'b0, 3'(i));
        opcode = op; flag_c = c; flag_z = z;
        repeat (ex.size()) @(posedge clk);
        #1;
    endtask

    task automatic run_hlt(input int n_idle);
        push_rec(S_PC_EN | S_MAR_LD, 1'b0, 3'd0);
        push_rec(S_RAM_EN | S_IR_LD | S_PC_INC, 1'b0, 3'd1);
        push_rec(15'h0, 1'b0, 3'd2);
        for (int i = 0; i < n_idle; i++) push_rec(15'h0, 1'b1, 3'd2);
        push_rec(15'h0, 1'b1, 3'd2);
        opcode = 4'hF; flag_c = $urandom_range(0, 1); flag_z = $urandom_range(0, 1);
        repeat (3 + n_idle) @(posedge clk);
        #1;
        opcode = 4'(($urandom_range(0, 14)));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic reset_mid_add();
        push_rec(S_PC_EN | S_MAR_LD, 1'b0, 3'd0);
        push_rec(S_RAM_EN | S_IR_LD | S_PC_INC, 1'b0, 3'd1);
        push_rec(S_IR_EN | S_MAR_LD, 1'b0, 3'd2);
        push_rec(15'h0, 1'b0, 3'd3);
        push_rec(15'h0, 1'b0, 3'd0);
        push_rec(15'h0, 1'b0, 3'd0);
        opcode = 4'h2; flag_c = 1'b0; flag_z = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
        @(posedge clk);
        #1;
        push_rec(15'h0, 1'b0, 3'd0);
        push_rec(15'h0, 1'b0, 3'd0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        reset_mid_add();
        run_instr(4'h5, 1'b0, 1'b0);
        run_instr(4'hE, 1'b0, 1'b0);
        run_instr(4'h2, 1'b1, 1'b0);
        run_instr(4'h3, 1'b0, 1'b1);
        run_instr(4'h7, 1'b0, 1'b1);
        run_instr(4'h7, 1'b1, 1'b0);
        run_instr(4'h8, 1'b1, 1'b0);
        run_instr(4'h8, 1'b0, 1'b1);
        run_instr(4'h1, 1'b0, 1'b0);
        run_instr(4'h4, 1'b0, 1'b0);
        run_instr(4'h6, 1'b0, 1'b0);
        run_instr(4'hA, 1'b1, 1'b1);
        run_hlt(20);

        for (int n = 0; n < 10000; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF) run_hlt($urandom_range(1, 4));
            else run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        mon_en = 1'b0;
        cmp_cnt++;
        if (sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL sb_drain actual %0d entries left required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sap_control_unit.md
Name: sap_control_unit

Overview:
Microsequencer for the 8-bit SAP CPU. Steps a T-state counter and decodes the 4-bit opcode held in the instruction register. Drives every load/enable strobe on the shared 8-bit bus: program counter, MAR, RAM, IR, A, B, ALU, flags and OUT. Sits beside the datapath and owns all bus arbitration; no other block asserts a bus enable.

Parameters:
T_LAST, 4, index of the last T-state (T0..T4); a step counter beyond it is never reached.
HLT_OPCODE, 4'hF, opcode that enters the halted state.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  4  IR[7:4], valid from T2 onward
flag_c  in  1  registered carry flag
flag_z  in  1  registered zero flag
pc_inc  out  1  increment program counter
pc_load  out  1  load PC from bus
pc_enable  out  1  PC drives bus
mar_load  out  1  load MAR from bus
ram_enable  out  1  RAM[MAR] drives bus
ram_load  out  1  write bus into RAM[MAR]
ir_load  out  1  load IR from bus
ir_enable  out  1  IR drives zero-extended operand IR[3:0] on bus
a_load  out  1  load A from bus
a_enable  out  1  A drives bus
b_load  out  1  load B from bus
alu_enable  out  1  ALU result drives bus
alu_sub  out  1  ALU subtracts (A-B) instead of adds
flags_load  out  1  capture C/Z from ALU
out_load  out  1  load output register from bus
halted  out  1  CPU stopped
t_state  out  3  current T-state (debug)

Behaviour:
- State: 3-bit step counter plus a halt bit, both registered.
- Strobes: combinational from step counter, opcode and flags. All strobes are 0 whenever rst=1 or halted=1.
- Reset: step=T0, halted=0, t_state=0.
- First cycle after rst falls: T0.
- Reset mid-instruction aborts the instruction; no strobe fires in the reset cycle.
- Fetch:
  - T0: pc_enable, mar_load.
  - T1: ram_enable, ir_load, pc_inc.
- Execute starts at T2. "end" means the next state is T0, so there are no idle T-states.
  - NOP 0x0: T2 end (3 cycles).
  - LDA 0x1: T2 ir_enable+mar_load; T3 ram_enable+a_load, end (4 cycles).
  - ADD 0x2: T2 ir_enable+mar_load; T3 ram_enable+b_load; T4 alu_enable+a_load+flags_load, end (5 cycles).
  - SUB 0x3: as ADD, with alu_sub=1 in T4 only.
  - STA 0x4: T2 ir_enable+mar_load; T3 a_enable+ram_load, end.
  - LDI 0x5: T2 ir_enable+a_load, end.
  - JMP 0x6: T2 ir_enable+pc_load, end.
  - JC 0x7: T2 ir_enable+pc_load only if flag_c=1, end either way.
  - JZ 0x8: as JC, using flag_z.
  - OUT 0xE: T2 a_enable+out_load, end.
  - HLT 0xF: T2 no strobes; halted<=1 at end of T2.
  - Unused opcodes 0x9-0xD: behave as NOP.
- Flags are sampled combinationally during T2; a flag changing in the same cycle is the flag register's responsibility.
- Halted: sticky until rst; step counter frozen; t_state holds 2.
- Bus invariant: at most one of pc_enable, ram_enable, ir_enable, a_enable, alu_enable is high in any cycle. At most one of pc_load and pc_inc is high.
- Step counter never exceeds T_LAST. A T4 with a non-ADD/SUB opcode is unreachable; defensively force next=T0.

Decomposition:
- Package sap_pkg: opcode localparams (OP_NOP..OP_HLT), T-state encodings T0..T4, and a control-word struct/bit indices for the 15 strobes.
- Sub-module sap_microcode_rom: purely combinational (step, opcode, flag_c, flag_z) -> {control word, last_step}.
- Top: step/halt registers and reset/halt gating.

Test Plan:
- Reset: hold rst 3 cycles mid-ADD (T3) -> all strobes 0 during rst; first post-reset cycle t_state=0 with pc_enable=1, mar_load=1.
- LDI then OUT (0x57, 0xE0) -> T2 of cycle 2 shows ir_enable+a_load; instruction 2 is T0,T1,T2 with a_enable+out_load at T2; total 6 cycles.
- ADD then SUB (0x2A, 0x3B) -> 5 cycles each; alu_sub=0 in ADD T4, 1 in SUB T4; flags_load high only in T4.
- JC with flag_c=0 then flag_c=1 (opcode 0x7) -> pc_load=0 in the first, pc_load=1 with ir_enable in the second; both return to T0 after T2.
- HLT (0xF) -> halted=1 from the cycle after T2; 20 further cycles show all strobes 0 and t_state=2; rst clears halted.
- Random opcode stream (10k instructions, random flags) -> bus-enable one-hot invariant holds every cycle; cycle count per opcode matches the Behaviour list.
